modular_invertor_param: RTL and testbench



---
 rtl/modular_invertor_param.sv | 168 ++++++++++++++++
 tb/tb_modular_invertor_param.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modular_invertor_param.sv
// Modular inverse a^-1 mod q (odd q) using the binary extended Euclidean algorithm.
// Operands are read from word-addressed BRAMs and the result is written back, word 0 first.
module modular_invertor_param #(
  parameter int unsigned OPERAND_WIDTH = 256,
  parameter int unsigned WORD_WIDTH    = 32,
  localparam int unsigned NUM_WORDS = OPERAND_WIDTH / WORD_WIDTH,
  localparam int unsigned ADDR_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  output logic                  rdy,
  output logic                  err,
  output logic [ADDR_W-1:0]     a_addr,
  output logic [ADDR_W-1:0]     q_addr,
  output logic [ADDR_W-1:0]     a1_addr,
  output logic                  a1_wren,
  input  logic [WORD_WIDTH-1:0] a_din,
  input  logic [WORD_WIDTH-1:0] q_din,
  output logic [WORD_WIDTH-1:0] a1_dout
);

  localparam int unsigned W    = OPERAND_WIDTH;
  localparam int unsigned CntW = ADDR_W + 1;
  localparam logic [CntW-1:0] LastLoad  = CntW'(NUM_WORDS);
  localparam logic [CntW-1:0] LastStore = CntW'(NUM_WORDS - 1);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);
  localparam logic [W-1:0]    One       = W'(1);

  typedef enum logic [2:0] {StIdle, StLoad, StCheck, StLoop, StStore} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  // buf holds operand a during LOAD/CHECK and the result while it is shifted out in STORE
  logic [W-1:0]    buf_q, buf_d;
  logic [W-1:0]    q_q, q_d;
  logic [W-1:0]    u_q, u_d, v_q, v_d;
  logic [W-1:0]    x1_q, x1_d, x2_q, x2_d;
  logic            err_q, err_d;

  logic [W:0]              x1_add, x2_add, x12_dif, x21_dif;
  logic [W-1:0]            x1_half, x2_half, x1_sub, x2_sub;
  logic [W+WORD_WIDTH-1:0] a_shift, q_shift;

  always_comb begin
    // Halving keeps the carry of x+q so (x+q)/2 is exact.
    x1_add  = {1'b0, x1_q} + {1'b0, q_q};
    x2_add  = {1'b0, x2_q} + {1'b0, q_q};
    x1_half = x1_q[0] ? x1_add[W:1] : (x1_q >> 1);
    x2_half = x2_q[0] ? x2_add[W:1] : (x2_q >> 1);
    x12_dif = {1'b0, x1_q} - {1'b0, x2_q};
    x21_dif = {1'b0, x2_q} - {1'b0, x1_q};
    x1_sub  = x12_dif[W] ? x12_dif[W-1:0] + q_q : x12_dif[W-1:0];
    x2_sub  = x21_dif[W] ? x21_dif[W-1:0] + q_q : x21_dif[W-1:0];
    a_shift = {a_din, buf_q} >> WORD_WIDTH;
    q_shift = {q_din, q_q} >> WORD_WIDTH;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    q_d     = q_q;
    u_d     = u_q;
    v_d     = v_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (ena) begin
          state_d = StLoad;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      StLoad: begin
        cnt_d = cnt_q + CntOne;
        // Read data lags the address by one cycle, so capture starts at cnt 1.
        if (cnt_q != '0) begin
          buf_d = a_shift[W-1:0];
          q_d   = q_shift[W-1:0];
        end
        if (cnt_q == LastLoad) begin
          state_d = StCheck;
          cnt_d   = '0;
        end
      end
      StCheck: begin
        if (buf_q == '0 || buf_q >= q_q || !q_q[0]) begin
          err_d   = 1'b1;
          buf_d   = '0;
          state_d = StStore;
        end else begin
          u_d     = buf_q;
          v_d     = q_q;
          x1_d    = One;
          x2_d    = '0;
          state_d = StLoop;
        end
      end
      StLoop: begin
        if (u_q == One || v_q == One) begin
          buf_d   = (u_q == One) ? x1_q : x2_q;
          state_d = StStore;
        end else if (u_q == '0 || v_q == '0) begin
          err_d   = 1'b1;
          buf_d   = '0;
          state_d = StStore;
        end else if (!u_q[0]) begin
          u_d  = u_q >> 1;
          x1_d = x1_half;
        end else if (!v_q[0]) begin
          v_d  = v_q >> 1;
          x2_d = x2_half;
        end else if (u_q >= v_q) begin
          u_d  = u_q - v_q;
          x1_d = x1_sub;
        end else begin
          v_d  = v_q - u_q;
          x2_d = x2_sub;
        end
      end
      StStore: begin
        buf_d = buf_q >> WORD_WIDTH;
        cnt_d = cnt_q + CntOne;
        if (cnt_q == LastStore) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      buf_q   <= '0;
      q_q     <= '0;
      u_q     <= '0;
      v_q     <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      q_q     <= q_d;
      u_q     <= u_d;
      v_q     <= v_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      err_q   <= err_d;
    end
  end

  assign rdy     = (state_q == StIdle);
  assign err     = err_q;
  assign a_addr  = (state_q == StLoad && cnt_q != LastLoad) ? cnt_q[ADDR_W-1:0] : '0;
  assign q_addr  = a_addr;
  assign a1_wren = (state_q == StStore);
  assign a1_addr = a1_wren ? cnt_q[ADDR_W-1:0] : '0;
  assign a1_dout = a1_wren ? buf_q[WORD_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_modular_invertor_param.sv
// Bench for modular_invertor_param: 256/32 and 64/16 instances with BRAM models, checked
// against known vectors and a number-theoretic model (gcd, a*a1 mod q == 1).
module tb_modular_invertor_param;

  localparam logic [255:0] Q256 =
    256'hffffffff00000001000000000000000000000000ffffffffffffffffffffffff;
  localparam logic [255:0] A1V =
    256'hd3e73ccd63a5b10da308c615bb9ebd3f76e2c5fccc256fd9f629dcc956bf2382;
  localparam logic [255:0] R1V =
    256'h93fb26d5d199bbb7232a4b7c98e97ba9bb7530d304b5f07736ea4027bbb57ecd;
  localparam logic [255:0] A2V =
    256'h57b6c628a5c4e870740b2517975ace2216acbe094ac54568b53212ef45e69d22;
  localparam logic [255:0] R2V =
    256'hcd2af4766642d7d2f3f3f67d92c575c496772ef7d55c75eb46bd07e8d5f9a4aa;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        ena_b, rdy_b, err_b, a1_wren_b;
  logic [2:0]  a_addr_b, q_addr_b, a1_addr_b;
  logic [31:0] a_din_b, q_din_b, a1_dout_b;
  logic        ena_s, rdy_s, err_s, a1_wren_s;
  logic [1:0]  a_addr_s, q_addr_s, a1_addr_s;
  logic [15:0] a_din_s, q_din_s, a1_dout_s;

  logic [255:0] a_b, q_b, r_b;
  logic [63:0]  a_s, q_s, r_s;
  logic         clr_b, clr_s;
  int           wr_b = 0;
  int           wr_s = 0;
  int           checks = 0;
  int           errors = 0;

  modular_invertor_param #(.OPERAND_WIDTH(256), .WORD_WIDTH(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena_b), .rdy(rdy_b), .err(err_b),
    .a_addr(a_addr_b), .q_addr(q_addr_b), .a1_addr(a1_addr_b), .a1_wren(a1_wren_b),
    .a_din(a_din_b), .q_din(q_din_b), .a1_dout(a1_dout_b)
  );

  modular_invertor_param #(.OPERAND_WIDTH(64), .WORD_WIDTH(16)) dut_s (
    .clk(clk), .rst_n(rst_n), .ena(ena_s), .rdy(rdy_s), .err(err_s),
    .a_addr(a_addr_s), .q_addr(q_addr_s), .a1_addr(a1_addr_s), .a1_wren(a1_wren_s),
    .a_din(a_din_s), .q_din(q_din_s), .a1_dout(a1_dout_s)
  );

  // BRAM models, 1-cycle read latency; result memory is pre-filled with ones per run
  always @(posedge clk) begin
    a_din_b <= a_b[a_addr_b*32 +: 32];
    q_din_b <= q_b[q_addr_b*32 +: 32];
    if (clr_b) r_b <= {256{1'b1}};
    else if (a1_wren_b) begin
      r_b[a1_addr_b*32 +: 32] <= a1_dout_b;
      wr_b <= wr_b + 1;
    end
  end

  always @(posedge clk) begin
    a_din_s <= a_s[a_addr_s*16 +: 16];
    q_din_s <= q_s[q_addr_s*16 +: 16];
    if (clr_s) r_s <= {64{1'b1}};
    else if (a1_wren_s) begin
      r_s[a1_addr_s*16 +: 16] <= a1_dout_s;
      wr_s <= wr_s + 1;
    end
  end

  function automatic logic [255:0] gcd_f(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] t;
    while (y != '0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic bit bad_operand(input logic [255:0] a, input logic [255:0] q);
    return (a == '0) || (a >= q) || !q[0] || (gcd_f(a, q) != 256'd1);
  endfunction

  function automatic bit inv_ok(input logic [255:0] a, input logic [255:0] q,
                                input logic [255:0] r);
    logic [511:0] p;
    p = {256'b0, a} * {256'b0, r};
    return (r < q) && ((p % {256'b0, q}) == 512'd1);
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v = {v[223:0], 32'($urandom)};
    return v;
  endfunction

  // Drives one operation; pulse_at >= 1 re-pulses ena that many cycles into the run.
  task automatic run_op(input bit big, input logic [255:0] a, input logic [255:0] q,
                        input int pulse_at, output logic [255:0] res, output logic e,
                        output int nwr, output int cyc, output bit to);
    int w0;
    @(negedge clk);
    if (big) begin a_b = a; q_b = q; clr_b = 1'b1; end
    else begin a_s = a[63:0]; q_s = q[63:0]; clr_s = 1'b1; end
    @(negedge clk);
    clr_b = 1'b0;
    clr_s = 1'b0;
    w0 = big ? wr_b : wr_s;
    if (big) ena_b = 1'b1; else ena_s = 1'b1;
    @(negedge clk);
    ena_b = 1'b0;
    ena_s = 1'b0;
    cyc = 1;
    while (!(big ? rdy_b : rdy_s) && cyc < 2000) begin
      if (cyc == pulse_at) begin
        if (big) ena_b = 1'b1; else ena_s = 1'b1;
      end
      @(negedge clk);
      ena_b = 1'b0;
      ena_s = 1'b0;
      cyc++;
    end
    to  = !(big ? rdy_b : rdy_s);
    res = big ? r_b : {192'b0, r_s};
    e   = big ? err_b : err_s;
    nwr = (big ? wr_b : wr_s) - w0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ena_b = 1'b0; ena_s = 1'b0; clr_b = 1'b0; clr_s = 1'b0;
    a_b = '0; q_b = '0; a_s = '0; q_s = '0;
    #12;
    checks++;
    if ({rdy_b, err_b, a1_wren_b} !== 3'b100) begin
      errors++; $display("FAIL reset_ctl_256 got %b exp 100", {rdy_b, err_b, a1_wren_b});
    end
    checks++;
    if ({a_addr_b, q_addr_b, a1_addr_b, a1_dout_b} !== '0) begin
      errors++; $display("FAIL reset_bus_256 got %h exp 0",
                         {a_addr_b, q_addr_b, a1_addr_b, a1_dout_b});
    end
    checks++;
    if ({rdy_s, err_s, a1_wren_s, a_addr_s, q_addr_s, a1_addr_s, a1_dout_s} !== 25'h1000000)
    begin
      errors++; $display("FAIL reset_64 got %h exp 1000000",
                         {rdy_s, err_s, a1_wren_s, a_addr_s, q_addr_s, a1_addr_s, a1_dout_s});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed_256();
    logic [255:0] av [4], ev [4], res;
    logic e; int nwr, cyc; bit to;
    av = '{A1V, A2V, 256'd1, Q256 - 256'd1};
    ev = '{R1V, R2V, 256'd1, Q256 - 256'd1};
    for (int i = 0; i < 4; i++) begin
      run_op(1'b1, av[i], Q256, 0, res, e, nwr, cyc, to);
      checks++;
      if (to) begin errors++; $display("FAIL dir256_%0d_timeout got busy exp rdy", i); end
      checks++;
      if (res !== ev[i]) begin
        errors++; $display("FAIL dir256_%0d_result got %h exp %h", i, res, ev[i]);
      end
      checks++;
      if (e !== 1'b0 || nwr != 8) begin
        errors++; $display("FAIL dir256_%0d_err_writes got %b/%0d exp 0/8", i, e, nwr);
      end
    end
  endtask

  task automatic test_width_64();
    logic [255:0] res; logic e; int nwr, cyc; bit to;
    run_op(1'b0, 256'd2, 256'hffffffff00000001, 0, res, e, nwr, cyc, to);
    checks++;
    if (to || res !== 256'h7fffffff80000001 || e !== 1'b0) begin
      errors++; $display("FAIL w64_inverse got %h err %b exp 7fffffff80000001 err 0", res, e);
    end
    checks++;
    if (nwr != 4) begin errors++; $display("FAIL w64_writes got %0d exp 4", nwr); end
  endtask

  task automatic test_errors_64();
    logic [255:0] av [4], qv [4], res; logic e; int nwr, cyc; bit to;
    av = '{256'h6, 256'h0, 256'hf, 256'h3};
    qv = '{256'hf, 256'hf, 256'hf, 256'h10};
    for (int i = 0; i < 4; i++) begin
      run_op(1'b0, av[i], qv[i], 0, res, e, nwr, cyc, to);
      checks++;
      if (to || e !== 1'b1) begin
        errors++; $display("FAIL err64_%0d_flag got %b (timeout %0d) exp 1", i, e, to);
      end
      checks++;
      if (res !== '0 || nwr != 4) begin
        errors++; $display("FAIL err64_%0d_zero got %h/%0d exp 0/4", i, res, nwr);
      end
    end
    run_op(1'b0, 256'd3, 256'hf1, 0, res, e, nwr, cyc, to);
    checks++;
    if (to || e !== 1'b0 || !inv_ok(256'd3, 256'hf1, res)) begin
      errors++; $display("FAIL err64_clear got %h err %b exp inverse err 0", res, e);
    end
  endtask

  task automatic test_random();
    logic [255:0] a, q, res; logic e; int nwr, cyc; bit to; bit bad;
    for (int i = 0; i < 24; i++) begin
      q = {192'b0, 32'($urandom), 32'($urandom)} | 256'd1;
      if (q < 256'd3) q = 256'd3;
      a = {192'b0, 32'($urandom), 32'($urandom)};
      if (i % 5 == 3) begin
        q = 256'd3 * {224'b0, 32'($urandom) | 32'd1};
        a = 256'd3 * {240'b0, 16'($urandom)};
      end else if (i % 5 != 4) a = a % q;
      bad = bad_operand(a, q);
      run_op(1'b0, a, q, 0, res, e, nwr, cyc, to);
      checks++;
      if (to || e !== bad || nwr != 4) begin
        errors++;
        $display("FAIL rnd64_%0d_flag a=%h q=%h got err %b wr %0d exp err %b wr 4",
                 i, a[63:0], q[63:0], e, nwr, bad);
      end
      checks++;
      if (bad ? (res !== '0) : !inv_ok(a, q, res)) begin
        errors++; $display("FAIL rnd64_%0d_result a=%h q=%h got %h", i, a[63:0], q[63:0],
                           res[63:0]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      a = rand256() % Q256;
      run_op(1'b1, a, Q256, 0, res, e, nwr, cyc, to);
      bad = bad_operand(a, Q256);
      checks++;
      if (to || e !== bad || (bad ? (res !== '0) : !inv_ok(a, Q256, res))) begin
        errors++; $display("FAIL rnd256_%0d a=%h got %h err %b", i, a, res, e);
      end
    end
  endtask

  task automatic test_busy_ena();
    logic [255:0] res; logic e; int nwr, cyc0, cyc1; bit to;
    run_op(1'b1, A1V, Q256, 0, res, e, nwr, cyc0, to);
    run_op(1'b1, A1V, Q256, 5, res, e, nwr, cyc1, to);
    checks++;
    if (to || res !== R1V || nwr != 8) begin
      errors++; $display("FAIL busy_ena_result got %h wr %0d exp %h wr 8", res, nwr, R1V);
    end
    checks++;
    if (cyc1 != cyc0) begin
      errors++; $display("FAIL busy_ena_latency got %0d exp %0d", cyc1, cyc0);
    end
  endtask

  task automatic test_reset_mid();
    logic [255:0] res; logic e; int nwr, cyc; bit to;
    @(negedge clk);
    a_b = A1V; q_b = Q256; ena_b = 1'b1;
    @(negedge clk);
    ena_b = 1'b0;
    repeat (30) @(negedge clk);
    checks++;
    if (rdy_b !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", rdy_b); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rdy_b, err_b, a1_wren_b, a_addr_b, a1_addr_b, a1_dout_b} !== {3'b100, 38'b0}) begin
      errors++; $display("FAIL midrst_values got rdy %b err %b wren %b exp 1 0 0",
                         rdy_b, err_b, a1_wren_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b1, A1V, Q256, 0, res, e, nwr, cyc, to);
    checks++;
    if (to || res !== R1V || e !== 1'b0 || nwr != 8) begin
      errors++; $display("FAIL midrst_rerun got %h err %b wr %0d exp %h", res, e, nwr, R1V);
    end
  endtask

  initial begin
    test_reset();
    test_directed_256();
    test_width_64();
    test_errors_64();
    test_random();
    test_busy_ena();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
